// File: rtl/lsu_master_pkg.sv
// rtl/lsu_master_pkg.sv - funct3 codes, sign_mask encodings, FSM states and decode record for lsu_master
package lsu_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // bit 3 requests sign extension, bits 2:0 select byte/half/word lanes
  localparam logic [3:0] SM_LB  = 4'b1001;
  localparam logic [3:0] SM_LH  = 4'b1011;
  localparam logic [3:0] SM_W   = 4'b0111;
  localparam logic [3:0] SM_LBU = 4'b0001;
  localparam logic [3:0] SM_LHU = 4'b0011;
  localparam logic [3:0] SM_SB  = 4'b0001;
  localparam logic [3:0] SM_SH  = 4'b0011;

  typedef struct packed {
    logic [3:0] sign_mask;
    logic       legal;
    logic       misaligned;
  } size_dec_t;

endpackage

// File: rtl/lsu_master_size_decode.sv
// rtl/lsu_master_size_decode.sv - maps funct3, we and addr[1:0] to {sign_mask, legal, misaligned}
module lsu_size_decode
  import lsu_master_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       we,
  input  logic [1:0] addr_lsb,
  output size_dec_t  dec
);

  always_comb begin
    dec = '0;
    unique case (funct3)
      F3_B: begin
        dec.sign_mask = we ? SM_SB : SM_LB;
        dec.legal     = 1'b1;
      end
      F3_H: begin
        dec.sign_mask  = we ? SM_SH : SM_LH;
        dec.legal      = 1'b1;
        dec.misaligned = addr_lsb[0];
      end
      F3_W: begin
        dec.sign_mask  = SM_W;
        dec.legal      = 1'b1;
        dec.misaligned = |addr_lsb;
      end
      F3_BU: begin
        dec.sign_mask = we ? 4'b0000 : SM_LBU;
        dec.legal     = !we;
      end
      F3_HU: begin
        dec.sign_mask  = we ? 4'b0000 : SM_LHU;
        dec.legal      = !we;
        dec.misaligned = !we && addr_lsb[0];
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// rtl/lsu_master.sv - load/store initiator from MEM stage to data_mem responder port
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W requests take the error path instead of issuing.
module lsu_master
  import lsu_master_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_memwrite,
  output logic          mem_memread,
  output logic [3:0]    mem_sign_mask,
  input  logic [DW-1:0] mem_read_data
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_e state, state_next;
  size_dec_t  dec;
  logic       err_req;
  logic       is_store;
  logic       accept, capture, enter_resp, done;

  lsu_size_decode u_size_decode (
    .funct3   (req_funct3),
    .we       (req_we),
    .addr_lsb (req_addr[1:0]),
    .dec      (dec)
  );

  assign err_req   = !dec.legal || (TRAP_EN && dec.misaligned);
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = err_req ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE:   state_next = is_store ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: begin
        capture    = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    enter_resp = (state_next == ST_RESP) && (state != ST_RESP);
  end

  // Strobes default low every cycle so each request pulses exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      is_store       <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
    end else begin
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      if (accept) begin
        mem_addr       <= req_addr;
        mem_write_data <= req_wdata;
        mem_sign_mask  <= dec.sign_mask;
        is_store       <= req_we;
        mem_memwrite   <= req_we && !err_req;
        mem_memread    <= !req_we && !err_req;
        rsp_rdata      <= '0;
        rsp_err        <= err_req;
      end
      if (capture)    rsp_rdata <= mem_read_data;
      if (enter_resp) rsp_valid <= 1'b1;
      if (done) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// tb/tb_lsu_master.sv - self-checking bench for lsu_master with data_mem responder and byte-level reference
module tb_lsu_master;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [31:0] rsp_rdata, mem_addr, mem_write_data, mem_read_data = '0;
  logic        mem_memwrite, mem_memread;
  logic [3:0]  mem_sign_mask;

  int total = 0, bad = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [3:0]  last_mask = '0;
  logic [31:0] dmem [16];
  logic [7:0]  rbytes [64];

  always #5 clk = ~clk;

  lsu_master #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data)
  );

  // data_mem responder: lane write, synchronous extracted read
  always @(posedge clk) begin
    logic [31:0] w, s;
    int idx;
    idx = int'(mem_addr[5:2]);
    w = dmem[idx];
    if (mem_memwrite) begin
      case (mem_sign_mask[2:0])
        3'b001: w[8*mem_addr[1:0] +: 8] = mem_write_data[7:0];
        3'b011: begin
          w[8*mem_addr[1:0] +: 8] = mem_write_data[7:0];
          if (mem_addr[1:0] != 2'd3) w[8*(mem_addr[1:0]+2'd1) +: 8] = mem_write_data[15:8];
        end
        default: w = mem_write_data;
      endcase
      dmem[idx] <= w;
    end
    if (mem_memread) begin
      s = w >> (8 * mem_addr[1:0]);
      case (mem_sign_mask[2:0])
        3'b001:  mem_read_data <= {{24{mem_sign_mask[3] & s[7]}}, s[7:0]};
        3'b011:  mem_read_data <= {{16{mem_sign_mask[3] & s[15]}}, s[15:0]};
        default: mem_read_data <= s;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mem_memread)  rd_cnt++;
    if (mem_memwrite) wr_cnt++;
    if (mem_memread && mem_memwrite) both_cnt++;
    if (mem_memread || mem_memwrite) last_mask = mem_sign_mask;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic legal, mis;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = (nbytes(f3) == 2 && a[0]) || (nbytes(f3) == 4 && a[1:0] != 2'd0);
    return !legal || (TRAP && mis);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = 0;
    for (int i = 0; i < n; i++) v |= 32'(rbytes[(int'(a[5:0]) + i) % 64]) << (8 * i);
    if (!f3[2] && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(f3); i++) rbytes[(int'(a[5:0]) + i) % 64] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {rbytes[4*idx+3], rbytes[4*idx+2], rbytes[4*idx+1], rbytes[4*idx]};
  endfunction

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold,
                         output logic [31:0] rd, output logic e, output int lat,
                         output int nrd, output int nwr, output logic [3:0] mk);
    int g, r0, w0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    check("accept_ready", {31'b0, req_ready}, 32'd1);
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin @(negedge clk); lat++; end
    rd = rsp_rdata; e = rsp_err; mk = last_mask;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    nrd = rd_cnt - r0; nwr = wr_cnt - w0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_dropped", {31'b0, rsp_valid}, 32'd0);
    check("idle_after_ready", {31'b0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
    int hold; logic [31:0] exp_rdata; logic exp_err; int exp_lat; logic [3:0] exp_mask;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] rd, exp_rd, wd, a;
  logic e, exp_e, we;
  logic [2:0] f3;
  logic [3:0] mk;
  int lat, nrd, nwr, off;

  initial begin
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    for (int i = 0; i < 64; i++) rbytes[i] = '0;

    // reset state
    #1;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    check("rst_strobes", {30'b0, mem_memread, mem_memwrite}, 32'd0);
    check("rst_sign_mask", {28'b0, mem_sign_mask}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vecs = '{
      '{1'b1, 3'b010, 32'h1004, 32'hDEADBEEF, 0, 32'h0,        1'b0, 2, 4'b0111},
      '{1'b1, 3'b010, 32'h1004, 32'h80FF7F01, 0, 32'h0,        1'b0, 2, 4'b0111},
      '{1'b0, 3'b000, 32'h1006, 32'h0,        0, 32'hFFFFFFFF, 1'b0, 3, 4'b1001},
      '{1'b0, 3'b100, 32'h1006, 32'h0,        0, 32'h000000FF, 1'b0, 3, 4'b0001},
      '{1'b0, 3'b001, 32'h1006, 32'h0,        0, 32'hFFFF80FF, 1'b0, 3, 4'b1011},
      '{1'b0, 3'b010, 32'h1004, 32'h0,        5, 32'h80FF7F01, 1'b0, 3, 4'b0111},
      '{1'b0, 3'b101, 32'h1006, 32'h0,        0, 32'h000080FF, 1'b0, 3, 4'b0011},
      '{1'b0, 3'b011, 32'h1004, 32'h0,        0, 32'h0,        1'b1, 1, 4'b0000},
      '{1'b0, 3'b010, 32'h1004, 32'h0,        1, 32'h80FF7F01, 1'b0, 3, 4'b0111},
      '{1'b1, 3'b000, 32'h1009, 32'h55AA,     0, 32'h0,        1'b0, 2, 4'b0001},
      '{1'b1, 3'b001, 32'h100A, 32'hAB1234,   0, 32'h0,        1'b0, 2, 4'b0011},
      '{1'b1, 3'b100, 32'h1008, 32'hFFFFFFFF, 0, 32'h0,        1'b1, 1, 4'b0000},
      '{1'b0, 3'b010, 32'h1008, 32'h0,        0, 32'h1234AA00, 1'b0, 3, 4'b0111},
      '{1'b1, 3'b010, 32'h2000, 32'h0000000F, 0, 32'h0,        1'b0, 2, 4'b0111}
    };
    foreach (vecs[i]) begin
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].hold, rd, e, lat, nrd, nwr, mk);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_strobes", i), {nrd[15:0], nwr[15:0]},
            vecs[i].exp_err ? 32'h0 : (vecs[i].we ? 32'h0000_0001 : 32'h0001_0000));
      if (!vecs[i].exp_err) begin
        check($sformatf("v%0d_mask", i), {28'b0, mk}, {28'b0, vecs[i].exp_mask});
        if (vecs[i].we) ref_store(vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      end
      if (i == 0) check("sw_word1", dmem[1], 32'hDEADBEEF);
    end

    // misaligned halfword load
    run_req(1'b0, 3'b001, 32'h1003, 32'h0, 0, rd, e, lat, nrd, nwr, mk);
    if (TRAP) begin
      check("mis_err", {31'b0, e}, 32'd1);
      check("mis_rdata", rd, 32'd0);
      check("mis_lat", lat, 1);
      check("mis_reads", nrd, 0);
    end else begin
      check("mis_err", {31'b0, e}, 32'd0);
      check("mis_lat", lat, 3);
      check("mis_reads", nrd, 1);
    end

    // reset asserted while the store strobe is high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h1008; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    check("rst_mid_strobe_up", {31'b0, mem_memwrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_strobe_down", {31'b0, mem_memwrite}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_word", dmem[2], ref_word(2));
    check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // randomized traffic against the byte-level reference
    for (int k = 0; k < 40; k++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      off = (nbytes(f3) == 1) ? int'($urandom_range(0, 3)) : (nbytes(f3) == 2) ? 2 * int'($urandom_range(0, 1)) : 0;
      a = 32'h1000 | (32'($urandom_range(0, 15)) << 2) | 32'(off);
      wd = $urandom;
      exp_e = ref_err(we, f3, a);
      exp_rd = (we || exp_e) ? 32'h0 : ref_load(f3, a);
      run_req(we, f3, a, wd, int'($urandom_range(0, 2)), rd, e, lat, nrd, nwr, mk);
      check($sformatf("rnd%0d_rdata", k), rd, exp_rd);
      check($sformatf("rnd%0d_err", k), {31'b0, e}, {31'b0, exp_e});
      check($sformatf("rnd%0d_lat", k), lat, exp_e ? 1 : (we ? 2 : 3));
      if (we && !exp_e) ref_store(f3, a, wd);
    end

    for (int i = 0; i < 16; i++) check($sformatf("final_word%0d", i), dmem[i], ref_word(i));
    check("never_both_strobes", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
